// File: rtl/stream_alu_if.sv
// Stream bundle for stream_alu: two operand channels, an opcode channel and
// one result channel, all on the stb/ack handshake.
interface stream_alu_if #(
  parameter int bits = 16
);
  logic [bits-1:0] in1;
  logic            in1_stb;
  logic            in1_ack;
  logic [bits-1:0] in2;
  logic            in2_stb;
  logic            in2_ack;
  logic [1:0]      op;
  logic            op_stb;
  logic            op_ack;
  logic [bits-1:0] out1;
  logic            out1_stb;
  logic            out1_ack;

  // Upstream/downstream side of the block
  modport master (
    output in1, in1_stb, in2, in2_stb, op, op_stb, out1_ack,
    input  in1_ack, in2_ack, op_ack, out1, out1_stb
  );

  // The arithmetic block itself
  modport slave (
    input  in1, in1_stb, in2, in2_stb, op, op_stb, out1_ack,
    output in1_ack, in2_ack, op_ack, out1, out1_stb
  );
endinterface

// File: rtl/stream_alu.sv
// Two-operand arithmetic stream block: collects A, B and an opcode on
// independent stb/ack channels, computes add/sub (optionally saturating) or
// the low/high half of the signed product, and offers the result on out1.
//
// state | meaning
// GET   | acks raised for every channel not yet captured; latch words
// EXEC  | compute on latched words, register result, raise out1_stb
// PUT   | hold result until out1_ack, then return to GET
module stream_alu #(
  parameter int bits     = 16,
  parameter bit saturate = 1'b0
) (
  input logic         clk,
  input logic         rst,
  stream_alu_if.slave bus
);

  typedef enum logic [1:0] {GET, EXEC, PUT} state_t;

  state_t          state;
  logic [bits-1:0] a_q;
  logic [bits-1:0] b_q;
  logic [1:0]      op_q;
  logic            a_got;
  logic            b_got;
  logic            op_got;
  logic            in1_ack_q;
  logic            in2_ack_q;
  logic            op_ack_q;
  logic [bits-1:0] out1_q;
  logic            out1_stb_q;

  logic            take_a;
  logic            take_b;
  logic            take_op;
  logic            all_got;
  logic [bits:0]     sum_ext;
  logic [2*bits-1:0] prod;
  logic [bits-1:0]   sat_max;
  logic [bits-1:0]   sat_min;
  logic [bits-1:0]   result;

  assign bus.in1_ack  = in1_ack_q;
  assign bus.in2_ack  = in2_ack_q;
  assign bus.op_ack   = op_ack_q;
  assign bus.out1     = out1_q;
  assign bus.out1_stb = out1_stb_q;

  // Acks are only ever high in GET, so a transfer implies we are collecting
  assign take_a  = bus.in1_stb & in1_ack_q;
  assign take_b  = bus.in2_stb & in2_ack_q;
  assign take_op = bus.op_stb  & op_ack_q;
  assign all_got = (a_got | take_a) & (b_got | take_b) & (op_got | take_op);

  // Datapath: one extra bit on add/sub exposes signed overflow; operands are
  // sign-extended to 2*bits so an unsigned multiply yields the signed product
  always_comb begin
    sat_max = {1'b0, {(bits-1){1'b1}}};
    sat_min = {1'b1, {(bits-1){1'b0}}};
    if (op_q == 2'd1) begin
      sum_ext = {a_q[bits-1], a_q} - {b_q[bits-1], b_q};
    end else begin
      sum_ext = {a_q[bits-1], a_q} + {b_q[bits-1], b_q};
    end
    prod = {{bits{a_q[bits-1]}}, a_q} * {{bits{b_q[bits-1]}}, b_q};
    case (op_q)
      2'd2:    result = prod[bits-1:0];
      2'd3:    result = prod[2*bits-1:bits];
      default: begin
        if (saturate && (sum_ext[bits] != sum_ext[bits-1])) begin
          result = sum_ext[bits] ? sat_min : sat_max;
        end else begin
          result = sum_ext[bits-1:0];
        end
      end
    endcase
  end

  // Control FSM with registered handshake outputs and operand latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= GET;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      a_got      <= 1'b0;
      b_got      <= 1'b0;
      op_got     <= 1'b0;
      in1_ack_q  <= 1'b0;
      in2_ack_q  <= 1'b0;
      op_ack_q   <= 1'b0;
      out1_q     <= '0;
      out1_stb_q <= 1'b0;
    end else begin
      case (state)
        GET: begin
          if (take_a) begin
            a_q       <= bus.in1;
            a_got     <= 1'b1;
            in1_ack_q <= 1'b0;
          end else if (!a_got) begin
            in1_ack_q <= 1'b1;
          end
          if (take_b) begin
            b_q       <= bus.in2;
            b_got     <= 1'b1;
            in2_ack_q <= 1'b0;
          end else if (!b_got) begin
            in2_ack_q <= 1'b1;
          end
          if (take_op) begin
            op_q     <= bus.op;
            op_got   <= 1'b1;
            op_ack_q <= 1'b0;
          end else if (!op_got) begin
            op_ack_q <= 1'b1;
          end
          if (all_got) begin
            state <= EXEC;
          end
        end
        EXEC: begin
          out1_q     <= result;
          out1_stb_q <= 1'b1;
          a_got      <= 1'b0;
          b_got      <= 1'b0;
          op_got     <= 1'b0;
          state      <= PUT;
        end
        PUT: begin
          if (bus.out1_ack) begin
            out1_stb_q <= 1'b0;
            state      <= GET;
          end
        end
        default: state <= GET;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_alu.sv
// Bench for stream_alu: a wrapping and a saturating instance are driven with
// identical stimulus; expected results are queued per instance when each
// transaction is issued and popped by a monitor on every out1 transfer.
module tb_stream_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_alu_if #(.bits(16)) if0 ();
  stream_alu_if #(.bits(16)) if1 ();

  stream_alu #(.bits(16), .saturate(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  stream_alu #(.bits(16), .saturate(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int          total = 0;
  int          bad = 0;
  int          ack_mode = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  bit          prev_stb[2];
  bit          prev_xfer[2];
  logic [15:0] prev_out[2];

  task automatic chk(string name, int d, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d got=%h want=%h at %0t", name, d, got, want, $time);
    end
  endtask

  // Reference arithmetic using plain integer math
  function automatic logic [15:0] model(logic [15:0] a, logic [15:0] b, logic [1:0] op, bit sat);
    longint x = longint'($signed(a));
    longint y = longint'($signed(b));
    longint r;
    case (op)
      2'd0:    r = x + y;
      2'd1:    r = x - y;
      default: r = x * y;
    endcase
    if (op == 2'd3) return r[31:16];
    if (op < 2'd2 && sat) begin
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
    end
    return r[15:0];
  endfunction

  task automatic set_ch(int d, int ch, logic [15:0] v, logic s);
    if (d == 0) begin
      case (ch)
        0:       begin if0.in1 = v; if0.in1_stb = s; end
        1:       begin if0.in2 = v; if0.in2_stb = s; end
        default: begin if0.op = v[1:0]; if0.op_stb = s; end
      endcase
    end else begin
      case (ch)
        0:       begin if1.in1 = v; if1.in1_stb = s; end
        1:       begin if1.in2 = v; if1.in2_stb = s; end
        default: begin if1.op = v[1:0]; if1.op_stb = s; end
      endcase
    end
  endtask

  function automatic logic get_ack(int d, int ch);
    if (d == 0) return (ch == 0) ? if0.in1_ack : (ch == 1) ? if0.in2_ack : if0.op_ack;
    return (ch == 0) ? if1.in1_ack : (ch == 1) ? if1.in2_ack : if1.op_ack;
  endfunction

  // Present one word on a channel of both instances; drop stb after transfer
  task automatic drive(int ch, logic [15:0] v, int dly);
    bit d0 = 0;
    bit d1 = 0;
    bit t0;
    bit t1;
    int n = 0;
    repeat (dly) @(posedge clk);
    #1;
    set_ch(0, ch, v, 1'b1);
    set_ch(1, ch, v, 1'b1);
    while (!(d0 && d1) && n < 300) begin
      @(negedge clk);
      t0 = !d0 && get_ack(0, ch);
      t1 = !d1 && get_ack(1, ch);
      @(posedge clk);
      #1;
      if (t0) begin set_ch(0, ch, v, 1'b0); d0 = 1; end
      if (t1) begin set_ch(1, ch, v, 1'b0); d1 = 1; end
      n++;
    end
    total++;
    if (!(d0 && d1)) begin
      bad++;
      $display("FAIL accept_ch%0d got=%0d%0d want=11", ch, d0, d1);
      set_ch(0, ch, v, 1'b0);
      set_ch(1, ch, v, 1'b0);
    end
  endtask

  task automatic txn(logic [15:0] a, logic [15:0] b, logic [1:0] op, int da, int db, int dop);
    q0.push_back(model(a, b, op, 1'b0));
    q1.push_back(model(a, b, op, 1'b1));
    fork
      drive(0, a, da);
      drive(1, b, db);
      drive(2, {14'b0, op}, dop);
    join
  endtask

  task automatic mon(int d, logic stb, logic ack, logic [15:0] out, logic any_ack);
    logic [15:0] w;
    if (rst) begin
      prev_stb[d]  = 1'b0;
      prev_xfer[d] = 1'b0;
      return;
    end
    if (prev_stb[d] && !prev_xfer[d]) begin
      chk("put_hold_stb", d, stb, 1);
      chk("put_hold_out", d, out, prev_out[d]);
    end
    if (stb) chk("acks_low_in_put", d, any_ack, 0);
    if (stb && ack) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        total++;
        bad++;
        $display("FAIL unexpected_result dut%0d got=%h want=none", d, out);
      end else begin
        if (d == 0) w = q0.pop_front();
        else        w = q1.pop_front();
        chk("result", d, out, w);
      end
    end
    prev_stb[d]  = stb;
    prev_xfer[d] = stb && ack;
    prev_out[d]  = out;
  endtask

  // Result monitor, sampled mid-cycle
  always @(negedge clk) begin
    mon(0, if0.out1_stb, if0.out1_ack, if0.out1, if0.in1_ack | if0.in2_ack | if0.op_ack);
    mon(1, if1.out1_stb, if1.out1_ack, if1.out1, if1.in1_ack | if1.in2_ack | if1.op_ack);
  end

  // Downstream acceptor: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    logic v;
    if0.out1_ack = 1'b0;
    if1.out1_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: v = 1'b0;
      endcase
      if0.out1_ack = v;
      if1.out1_ack = v;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_q0", 0, q0.size(), 0);
    chk("drain_q1", 1, q1.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] hold;
    logic [15:0] corners[4];
    logic [15:0] a;
    logic [15:0] b;
    int n;
    corners[0] = 16'h7fff; corners[1] = 16'h8000;
    corners[2] = 16'hffff; corners[3] = 16'h0000;
    for (int d = 0; d < 2; d++) for (int c = 0; c < 3; c++) set_ch(d, c, 16'h0, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out1_stb", 0, if0.out1_stb, 0);
    chk("rst_out1", 0, if0.out1, 0);
    chk("rst_acks", 0, {if0.in1_ack, if0.in2_ack, if0.op_ack}, 0);
    rst = 1'b0;
    ack_mode = 0;

    // Basic add with latency and single-cycle result strobe
    txn(16'd3, 16'd4, 2'd0, 0, 0, 0);
    chk("t1_stb_at_capture", 0, if0.out1_stb, 0);
    @(posedge clk); #1;
    chk("t1_stb_rise", 0, if0.out1_stb, 1);
    chk("t1_out1", 0, if0.out1, 16'd7);
    @(posedge clk); #1;
    chk("t1_stb_fall", 0, if0.out1_stb, 0);
    chk("t1_acks_still_low", 0, {if0.in1_ack, if0.in2_ack, if0.op_ack}, 0);
    @(posedge clk); #1;
    chk("t1_acks_return", 0, {if0.in1_ack, if0.in2_ack, if0.op_ack}, 3'b111);

    // Order independence, saturation corners, multiply halves
    txn(16'd2, 16'd5, 2'd1, 6, 3, 0);
    txn(16'h7fff, 16'd1, 2'd0, 0, 1, 2);
    txn(16'h8000, 16'd1, 2'd1, 2, 0, 1);
    txn(16'h4000, 16'h0004, 2'd2, 0, 0, 0);
    txn(16'h4000, 16'h0004, 2'd3, 1, 1, 0);
    txn(16'hfffe, 16'd3, 2'd3, 0, 2, 1);
    drain();

    // Backpressure: result held while next operands wait
    ack_mode = 2;
    txn(16'd100, 16'd23, 2'd0, 0, 0, 0);
    fork
      txn(16'hfffb, 16'd9, 2'd2, 0, 0, 0);
      begin
        n = 0;
        while (!if0.out1_stb && n < 20) begin
          @(posedge clk); #1;
          n++;
        end
        chk("bp_stb", 0, if0.out1_stb, 1);
        hold = if0.out1;
        repeat (10) begin
          @(posedge clk); #1;
          chk("bp_out_stable", 0, if0.out1, hold);
          chk("bp_in_acks", 0, {if0.in1_ack, if0.in2_ack, if0.op_ack}, 0);
        end
        ack_mode = 0;
      end
    join
    drain();

    // Reset with A and op captured but B outstanding
    fork
      drive(0, 16'd9, 0);
      drive(2, 16'd0, 0);
    join
    chk("pre_rst_b_ack", 0, if0.in2_ack, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_acks", 0, {if0.in1_ack, if0.in2_ack, if0.op_ack}, 0);
    chk("mid_rst_stb", 0, if0.out1_stb, 0);
    chk("mid_rst_out1", 0, if0.out1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    txn(16'd1, 16'd1, 2'd0, 0, 0, 0);
    drain();

    // Randomised traffic with random downstream readiness
    ack_mode = 1;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
      txn(a, b, 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3));
    end
    ack_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
